// File: rtl/pref_ctrl_if.sv
// Handshake and buffer-control bundle between the tile sequencer and the prefetch controller.
interface pref_ctrl_if #(
  parameter int ROWS   = 4,
  parameter int ADDR_W = 8
);
  logic              start;
  logic              layer_first;
  logic [ADDR_W-1:0] tile_len;
  logic              sa_ready;
  logic              buf_rd_en;
  logic [ADDR_W-1:0] buf_rd_addr;
  logic              src_sel;
  logic              buf_select;
  logic              pref_en;
  logic [ROWS-1:0]   row_valid;
  logic              busy;
  logic              done;

  modport master (
    output start, layer_first, tile_len, sa_ready,
    input  buf_rd_en, buf_rd_addr, src_sel, buf_select, pref_en, row_valid, busy, done
  );

  modport slave (
    input  start, layer_first, tile_len, sa_ready,
    output buf_rd_en, buf_rd_addr, src_sel, buf_select, pref_en, row_valid, busy, done
  );
endinterface

// File: rtl/pref_ctrl.sv
// Prefetch controller: streams one tile of vectors out of the input or active output
// buffer, generates the skewed per-row valid flags for the systolic array and flips
// the ping-pong output buffer after tiles sourced from an output buffer.
module pref_ctrl #(
  parameter int ROWS   = 4,
  parameter int ADDR_W = 8
) (
  input logic      clk,
  input logic      reset,
  pref_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  localparam int DW = (ROWS > 1) ? $clog2(ROWS) : 1;

  state_t            state, state_d;
  logic [ADDR_W-1:0] cnt, cnt_d;
  logic [ADDR_W-1:0] len, len_d;
  logic [ADDR_W-1:0] addr, addr_d;
  logic [DW-1:0]     drain, drain_d;
  logic              rd_en, rd_en_d;
  logic              src, src_d;
  logic              bsel, bsel_d;
  logic              done, done_d;
  logic              pref;
  logic              busy;
  logic [ROWS-1:0]   rv;

  // Next-state and next-output logic; every output is registered from these values.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    len_d   = len;
    addr_d  = addr;
    drain_d = drain;
    rd_en_d = 1'b0;
    src_d   = src;
    bsel_d  = bsel;
    done_d  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          src_d   = ~bus.layer_first;
          len_d   = bus.tile_len;
          cnt_d   = '0;
          drain_d = '0;
          state_d = (bus.tile_len != '0) ? FETCH : DONE;
        end
      end
      FETCH: begin
        if (bus.sa_ready) begin
          rd_en_d = 1'b1;
          addr_d  = cnt;
          // The counter stops at len-1 rather than wrapping; the last read hands off to DRAIN.
          if (cnt == len - ADDR_W'(1)) begin
            state_d = DRAIN;
            drain_d = '0;
          end else begin
            cnt_d = cnt + ADDR_W'(1);
          end
        end
      end
      DRAIN: begin
        if (drain == DW'(ROWS - 1)) begin
          state_d = DONE;
        end else begin
          drain_d = drain + DW'(1);
        end
      end
      DONE: begin
        done_d = 1'b1;
        if (src && (len != '0)) begin
          bsel_d = ~bsel;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset overrides any in-flight tile.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      len   <= '0;
      addr  <= '0;
      drain <= '0;
      rd_en <= 1'b0;
      src   <= 1'b0;
      bsel  <= 1'b0;
      done  <= 1'b0;
      pref  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      len   <= len_d;
      addr  <= addr_d;
      drain <= drain_d;
      rd_en <= rd_en_d;
      src   <= src_d;
      bsel  <= bsel_d;
      done  <= done_d;
      pref  <= rd_en;
      busy  <= (state != IDLE);
    end
  end

  // Row-valid skew chain: row 0 tracks the prefetch load, each later row lags by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rv <= '0;
    end else begin
      rv[0] <= rd_en;
      for (int unsigned r = 1; r < ROWS; r++) begin
        rv[r] <= rv[r-1];
      end
    end
  end

  assign bus.buf_rd_en   = rd_en;
  assign bus.buf_rd_addr = addr;
  assign bus.src_sel     = src;
  assign bus.buf_select  = bsel;
  assign bus.pref_en     = pref;
  assign bus.row_valid   = rv;
  assign bus.busy        = busy;
  assign bus.done        = done;

endmodule
